round_sequencer: RTL and testbench

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/pong_pkg.sv | 41 ++++
 rtl/bcd_counter2.sv | 38 +++
 rtl/round_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_round_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared definitions for the pong round sequencer.
//                - state_t  : round sequencer state encoding
//                - bcd_inc  : two-digit BCD increment (ones 9->0 carries tens)
//                - to_bcd2  : integer (0..99) to two-digit BCD constant
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_POINT      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_t;

    localparam int FRAME_CNT_W = 8;

    // {tens, ones} + 1 in BCD; 99 wraps to 00 (never reached, scores stop
    // at the game limit).
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        result = value;
        if (value[3:0] == 4'd9) begin
            result[3:0] = 4'd0;
            result[7:4] = (value[7:4] == 4'd9) ? 4'd0 : value[7:4] + 4'd1;
        end else begin
            result[3:0] = value[3:0] + 4'd1;
        end
        return result;
    endfunction

    function automatic logic [7:0] to_bcd2(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter2.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter2
//  Description : Two-digit BCD counter with synchronous clear and increment.
//                Clear has priority over increment.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset (count -> 00)
//                clr   - synchronous clear to 00
//                inc   - add one (BCD)
//                ones  - ones digit
//                tens  - tens digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter2
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (clr) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (inc) begin
            {tens, ones} <= bcd_inc({tens, ones});
        end
    end

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer
//  Description : Pong round/score sequencer. Waits for a start press, holds
//                the ball before each serve, enables play, books points in
//                BCD, holds after each point and declares a winner once a
//                player reaches GAME_LIMIT. All outputs are registered.
//  Ports       : i_clk, i_rst_n (async, active low)
//                i_start      - start/restart level (rising edge used)
//                i_pause      - freezes play and hold countdowns
//                i_frame_tick - one pulse per video frame
//                i_point_p1/2 - point pulses from ball physics (P1 priority)
//                o_ball_en    - ball physics may advance
//                o_ball_reset - one-cycle recentre pulse
//                o_serve_dir  - 0 toward P2, 1 toward P1
//                o_score_*    - BCD scores (d1 ones, d2 tens)
//                o_finish     - game over
//                o_winner     - 0 P1, 1 P2 (valid with o_finish)
//  Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer
    import pong_pkg::*;
#(
    parameter int GAME_LIMIT   = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_frame_tick,
    input  logic       i_point_p1,
    input  logic       i_point_p2,
    output logic       o_ball_en,
    output logic       o_ball_reset,
    output logic       o_serve_dir,
    output logic [3:0] o_score_p1d1,
    output logic [3:0] o_score_p1d2,
    output logic [3:0] o_score_p2d1,
    output logic [3:0] o_score_p2d2,
    output logic       o_finish,
    output logic       o_winner
);

    // Terminal counter values: the transition fires on the tick that would
    // bring the count up to the frame total.
    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] POINT_LAST = FRAME_CNT_W'(POINT_FRAMES - 1);
    localparam logic [7:0]             LIMIT_BCD  = to_bcd2(GAME_LIMIT);

    state_t                 state;
    state_t                 state_nxt;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [FRAME_CNT_W-1:0] frame_cnt_nxt;

    logic start_q;
    logic start_arm;
    logic start_evt;
    logic tick_ok;

    logic ball_en_nxt;
    logic ball_reset_nxt;
    logic serve_dir_nxt;
    logic finish_nxt;
    logic winner_nxt;

    logic clr_scores;
    logic inc_p1;
    logic inc_p2;

    logic [3:0] p1_ones;
    logic [3:0] p1_tens;
    logic [3:0] p2_ones;
    logic [3:0] p2_tens;
    logic       p1_at_limit;
    logic       p2_at_limit;

    // start_arm stays low for the first clock after reset so that a button
    // already held through reset only primes the history bit instead of
    // being taken as a fresh press.
    assign start_evt   = start_arm & i_start & ~start_q;
    assign tick_ok     = i_frame_tick & ~i_pause;
    assign p1_at_limit = ({p1_tens, p1_ones} == LIMIT_BCD);
    assign p2_at_limit = ({p2_tens, p2_ones} == LIMIT_BCD);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            frame_cnt    <= '0;
            start_q      <= 1'b0;
            start_arm    <= 1'b0;
            o_ball_en    <= 1'b0;
            o_ball_reset <= 1'b0;
            o_serve_dir  <= 1'b0;
            o_finish     <= 1'b0;
            o_winner     <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_cnt    <= frame_cnt_nxt;
            start_q      <= i_start;
            start_arm    <= 1'b1;
            o_ball_en    <= ball_en_nxt;
            o_ball_reset <= ball_reset_nxt;
            o_serve_dir  <= serve_dir_nxt;
            o_finish     <= finish_nxt;
            o_winner     <= winner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        frame_cnt_nxt  = frame_cnt;
        ball_reset_nxt = 1'b0;
        serve_dir_nxt  = o_serve_dir;
        finish_nxt     = o_finish;
        winner_nxt     = o_winner;
        clr_scores     = 1'b0;
        inc_p1         = 1'b0;
        inc_p2         = 1'b0;

        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_evt) begin
                    state_nxt      = ST_SERVE_WAIT;
                    frame_cnt_nxt  = '0;
                    clr_scores     = 1'b1;
                    serve_dir_nxt  = 1'b0;
                    ball_reset_nxt = 1'b1;
                    finish_nxt     = 1'b0;
                    winner_nxt     = 1'b0;
                end
            end

            ST_SERVE_WAIT: begin
                if (tick_ok) begin
                    if (frame_cnt == SERVE_LAST) begin
                        state_nxt     = ST_PLAY;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end

            ST_PLAY: begin
                // P1 is checked first so a simultaneous pair credits P1 only.
                if (i_point_p1) begin
                    inc_p1        = 1'b1;
                    serve_dir_nxt = 1'b0;
                    state_nxt     = ST_POINT;
                    frame_cnt_nxt = '0;
                end else if (i_point_p2) begin
                    inc_p2        = 1'b1;
                    serve_dir_nxt = 1'b1;
                    state_nxt     = ST_POINT;
                    frame_cnt_nxt = '0;
                end
            end

            ST_POINT: begin
                if (tick_ok) begin
                    if (frame_cnt == POINT_LAST) begin
                        frame_cnt_nxt = '0;
                        if (p1_at_limit || p2_at_limit) begin
                            state_nxt  = ST_GAME_OVER;
                            finish_nxt = 1'b1;
                            winner_nxt = p2_at_limit;
                        end else begin
                            state_nxt      = ST_SERVE_WAIT;
                            ball_reset_nxt = 1'b1;
                        end
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt     = ST_IDLE;
                frame_cnt_nxt = '0;
            end
        endcase

        // Ball runs only while the next state is PLAY and not paused.
        ball_en_nxt = (state_nxt == ST_PLAY) && !i_pause;
    end

    // ------------------------------------------------------------------
    // Per-player BCD scores
    // ------------------------------------------------------------------
    bcd_counter2 u_score_p1 (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (clr_scores),
        .inc   (inc_p1),
        .ones  (p1_ones),
        .tens  (p1_tens)
    );

    bcd_counter2 u_score_p2 (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (clr_scores),
        .inc   (inc_p2),
        .ones  (p2_ones),
        .tens  (p2_tens)
    );

    assign o_score_p1d1 = p1_ones;
    assign o_score_p1d2 = p1_tens;
    assign o_score_p2d1 = p2_ones;
    assign o_score_p2d2 = p2_tens;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_sequencer
//  Description : Self-checking bench for round_sequencer. Two instances
//                (default parameters, and GAME_LIMIT=15 with short holds)
//                share one random stimulus stream and are compared every
//                cycle against an integer-score reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_round_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic pause;
    logic frame_tick;
    logic point_p1;
    logic point_p2;

    logic [1:0] ball_en;
    logic [1:0] ball_reset;
    logic [1:0] serve_dir;
    logic [1:0] finish;
    logic [1:0] winner;
    logic [3:0] p1d1 [2];
    logic [3:0] p1d2 [2];
    logic [3:0] p2d1 [2];
    logic [3:0] p2d2 [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    round_sequencer u_dut0 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_pause      (pause),
        .i_frame_tick (frame_tick),
        .i_point_p1   (point_p1),
        .i_point_p2   (point_p2),
        .o_ball_en    (ball_en[0]),
        .o_ball_reset (ball_reset[0]),
        .o_serve_dir  (serve_dir[0]),
        .o_score_p1d1 (p1d1[0]),
        .o_score_p1d2 (p1d2[0]),
        .o_score_p2d1 (p2d1[0]),
        .o_score_p2d2 (p2d2[0]),
        .o_finish     (finish[0]),
        .o_winner     (winner[0])
    );

    round_sequencer #(
        .GAME_LIMIT   (15),
        .SERVE_FRAMES (3),
        .POINT_FRAMES (2)
    ) u_dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_pause      (pause),
        .i_frame_tick (frame_tick),
        .i_point_p1   (point_p1),
        .i_point_p2   (point_p2),
        .o_ball_en    (ball_en[1]),
        .o_ball_reset (ball_reset[1]),
        .o_serve_dir  (serve_dir[1]),
        .o_score_p1d1 (p1d1[1]),
        .o_score_p1d2 (p1d2[1]),
        .o_score_p2d1 (p2d1[1]),
        .o_score_p2d2 (p2d2[1]),
        .o_finish     (finish[1]),
        .o_winner     (winner[1])
    );

    // ------------------------------------------------------------------
    // Reference model: phase 0 idle, 1 serve hold, 2 play, 3 point hold,
    // 4 game over. Holds count down remaining ticks; scores are integers.
    // ------------------------------------------------------------------
    int lim [2] = '{5, 15};
    int sfr [2] = '{60, 3};
    int pfr [2] = '{30, 2};

    int ph   [2];
    int left [2];
    int s1   [2];
    int s2   [2];
    bit m_en [2];
    bit m_rs [2];
    bit m_dir[2];
    bit m_fin[2];
    bit m_win[2];
    bit prev [2];
    bit armed[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; left[k] = 0; s1[k] = 0; s2[k] = 0;
            m_en[k] = 0; m_rs[k] = 0; m_dir[k] = 0; m_fin[k] = 0; m_win[k] = 0;
            prev[k] = 0; armed[k] = 0;
        end
    endtask

    task automatic model_step();
        bit evt;
        bit tk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            evt      = armed[k] && start && !prev[k];
            prev[k]  = start;
            armed[k] = 1;
            tk       = frame_tick && !pause;
            m_rs[k]  = 0;
            case (ph[k])
                0, 4: if (evt) begin
                    s1[k] = 0; s2[k] = 0; m_dir[k] = 0; m_rs[k] = 1;
                    m_fin[k] = 0; ph[k] = 1; left[k] = sfr[k];
                end
                1: if (tk) begin
                    left[k]--;
                    if (left[k] == 0) ph[k] = 2;
                end
                2: if (point_p1) begin
                    s1[k]++; m_dir[k] = 0; ph[k] = 3; left[k] = pfr[k];
                end else if (point_p2) begin
                    s2[k]++; m_dir[k] = 1; ph[k] = 3; left[k] = pfr[k];
                end
                3: if (tk) begin
                    left[k]--;
                    if (left[k] == 0) begin
                        if (s1[k] == lim[k] || s2[k] == lim[k]) begin
                            ph[k] = 4; m_fin[k] = 1; m_win[k] = (s2[k] == lim[k]);
                        end else begin
                            ph[k] = 1; left[k] = sfr[k]; m_rs[k] = 1;
                        end
                    end
                end
                default: ph[k] = 0;
            endcase
            m_en[k] = (ph[k] == 2) && !pause;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.ball_en", k),    ball_en[k],    m_en[k]);
            check($sformatf("u%0d.ball_reset", k), ball_reset[k], m_rs[k]);
            check($sformatf("u%0d.serve_dir", k),  serve_dir[k],  m_dir[k]);
            check($sformatf("u%0d.finish", k),     finish[k],     m_fin[k]);
            if (m_fin[k])
                check($sformatf("u%0d.winner", k), winner[k], m_win[k]);
            check($sformatf("u%0d.p1d1", k), p1d1[k], s1[k] % 10);
            check($sformatf("u%0d.p1d2", k), p1d2[k], s1[k] / 10);
            check($sformatf("u%0d.p2d1", k), p2d1[k], s2[k] % 10);
            check($sformatf("u%0d.p2d2", k), p2d2[k], s2[k] / 10);
        end
    endtask

    // One clock: drive at the falling edge (reset acts immediately, so it
    // is checked #1 later), then step the model at the rising edge.
    task automatic drive(input bit r, input bit st, input bit pz,
                         input bit ft, input bit a, input bit b);
        @(negedge clk);
        rst_n = r; start = st; pause = pz; frame_tick = ft;
        point_p1 = a; point_p2 = b;
        if (!r) model_reset();
        #1 check_all();
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    bit st_lvl = 0;
    bit pz_lvl = 0;

    task automatic random_cycles(input int n, input bit only_p1);
        bit a;
        bit b;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 299) == 0) st_lvl = ~st_lvl;
            if ($urandom_range(0, 59) == 0)  pz_lvl = ~pz_lvl;
            a = ($urandom_range(0, 7) == 0);
            b = only_p1 ? 1'b0 : ($urandom_range(0, 7) == 0);
            drive(1'b1, st_lvl, pz_lvl, 1'($urandom_range(0, 1)), a, b);
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; pause = 1'b0;
        frame_tick = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
        model_reset();

        // Reset state, then release with start already held high.
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Genuine press: ball reset pulse, then the default serve hold.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (70) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Simultaneous points in play credit P1.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (40) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        st_lvl = 1'b1;

        random_cycles(12000, 1'b0);
        random_cycles(8000, 1'b1);

        // Run until the default instance is in play, then reset mid-play
        // while start is held high.
        guard = 0;
        while (ph[0] != 2 && guard < 5000) begin
            random_cycles(1, 1'b0);
            guard++;
        end
        check("reach_play", (ph[0] == 2), 1);
        repeat (3)  drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        st_lvl = 1'b1;

        random_cycles(6000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
